// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: host-tx state encoding, command/response bytes, frame packing.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } tx_state_t;

  localparam logic [7:0] PS2_CMD_LED   = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_BREAK     = 8'hF0;

  // Bits after the start bit: data LSB first, then odd parity in the MSB.
  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  function automatic ps2_frame_t make_frame(input logic [7:0] d);
    ps2_frame_t f;
    f.parity = ~^d;
    f.data   = d;
    return f;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command request / status bundle between a caller and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout_err
  );
endinterface

// File: rtl/ps2_host_tx_edge_sync.sv
// PS/2 line synchronizer: 3-stage clock with falling-edge detect, 2-stage data.
// Line-agnostic, so the keyboard receiver can share it.
module ps2_host_tx_edge_sync (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_lvl,
  output logic clk_fall,
  output logic data_lvl
);
  logic [2:0] clk_sync;
  logic [1:0] data_sync;

  // Reset to the idle (pulled-up) level so release of reset never looks like a fall.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
    end
  end

  assign clk_lvl  = clk_sync[1];
  assign clk_fall = clk_sync[2] & ~clk_sync[1];
  assign data_lvl = data_sync[1];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked 8O1 frame, ACK.
// Line drives are combinational from state so an async reset releases both lines at once.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  ps2_host_tx_if.slave tx
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  tx_state_t        state, state_nx;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       bit_n;
  logic [8:0]       shift;

  logic clk_lvl, clk_fall, data_lvl;
  logic inh_last, tmo_run, tmo_hit;
  logic rdy, bsy, dn, aerr, terr;

  ps2_host_tx_edge_sync u_sync (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .clk_lvl   (clk_lvl),
    .clk_fall  (clk_fall),
    .data_lvl  (data_lvl)
  );

  assign inh_last = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
  assign tmo_run  = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
  assign tmo_hit  = tmo_run && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Timeout is checked first in every device-clocked state, so it wins over a same-cycle fall.
  always_comb begin
    state_nx    = state;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    rdy         = 1'b0;
    bsy         = 1'b1;
    dn          = 1'b0;
    aerr        = 1'b0;
    terr        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bsy = 1'b0;
        rdy = 1'b1;
        if (tx.tx_valid) state_nx = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_last) state_nx = ST_START;
      end
      ST_START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        state_nx    = ST_SHIFT;
      end
      ST_SHIFT: begin
        // bit_n==0 still holds the start bit; afterwards shift[0] is the bit on the wire.
        ps2_data_oe = (bit_n == 4'd0) | ~shift[0];
        if (tmo_hit) begin
          ps2_data_oe = 1'b0;
          terr        = 1'b1;
          state_nx    = ST_IDLE;
        end else if (clk_fall && bit_n == 4'd9) begin
          state_nx = ST_ACK;
        end
      end
      ST_ACK: begin
        if (tmo_hit) begin
          terr     = 1'b1;
          state_nx = ST_IDLE;
        end else if (clk_fall) begin
          if (data_lvl) begin
            aerr     = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (tmo_hit) begin
          terr     = 1'b1;
          state_nx = ST_IDLE;
        end else if (clk_lvl && data_lvl) begin
          dn       = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inh_cnt <= '0;
      shift   <= '1;
    end else if (state == ST_IDLE && tx.tx_valid) begin
      inh_cnt <= '0;
      shift   <= make_frame(tx.tx_data);
    end else if (state == ST_INHIBIT && !inh_last) begin
      inh_cnt <= inh_cnt + 1'b1;
    end else if (state == ST_SHIFT && clk_fall && !tmo_hit && bit_n != 4'd0) begin
      shift <= {1'b1, shift[8:1]};
    end
  end

  // Counters stop at their terminal count because the FSM leaves the counting state there.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tmo_cnt <= '0;
      bit_n   <= '0;
    end else if (state == ST_START) begin
      tmo_cnt <= '0;
      bit_n   <= '0;
    end else begin
      if (tmo_run && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == ST_SHIFT && clk_fall && !tmo_hit) bit_n <= bit_n + 1'b1;
    end
  end

  assign tx.tx_ready    = rdy;
  assign tx.busy        = bsy;
  assign tx.done        = dn;
  assign tx.ack_err     = aerr;
  assign tx.timeout_err = terr;
endmodule
